// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and default sizing for the UART transmit arbiter.
//   state_t          - arbiter FSM states (IDLE, LAUNCH, WAIT, COMPLETE)
//   DEFAULT_NUM_REQ  - default number of byte producers
//   DEFAULT_DATA_W   - default byte width (matches the UART transmitter)
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT     = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_DATA_W  = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational rotating-priority picker.
//   req  [NUM_REQ-1:0] - request vector
//   last [IDX_W-1:0]   - index granted last; search starts at last+1 (mod NUM_REQ)
//   gnt  [NUM_REQ-1:0] - one-hot grant (all zero when nothing is requested)
//   idx  [IDX_W-1:0]   - index of the granted request
//   any                - at least one request is present
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int unsigned j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    // Offsets 1..NUM_REQ visit every index once, ending on last itself.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      j = (32'(last) + i) % NUM_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among
// NUM_REQ byte producers.
//   clk, rst      - clock, synchronous active-high reset
//   enable        - allows new grants; an in-flight byte always completes
//   req_valid     - per-requester byte pending
//   req_data      - requester i byte at [i*DATA_W +: DATA_W]
//   req_ready     - one-hot accept, only in IDLE
//   req_done      - one-cycle completion pulse to the owner
//   tx_start      - one-cycle launch pulse to the transmitter
//   tx_data       - byte held from LAUNCH through COMPLETE
//   tx_done       - transmitter completion pulse (honoured only in WAIT)
//   busy          - FSM not in IDLE
//   owner         - current or last granted requester
//   timeout_err   - watchdog abort pulse, coincident with req_done
// Build option: define UART_ARB_TIMEOUT_EN to add the WAIT watchdog
// (TIMEOUT_CYC cycles); otherwise WAIT is unbounded and timeout_err is 0.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ     = DEFAULT_NUM_REQ,
  parameter  int DATA_W      = DEFAULT_DATA_W,
  parameter  int TIMEOUT_CYC = 4096,
  localparam int OWNER_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    req_done,
  output logic                  tx_start,
  output logic [DATA_W-1:0]     tx_data,
  input  logic                  tx_done,
  output logic                  busy,
  output logic [OWNER_W-1:0]    owner,
  output logic                  timeout_err
);

  if (NUM_REQ < 2 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ and TIMEOUT_CYC must be >= 2");
  end

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    tx_data_q;
  logic [OWNER_W-1:0]   owner_q, last_q;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [OWNER_W-1:0]   pick_idx;
  logic                 pick_any;
  logic                 accept;
  logic                 to_hit;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OWNER_W)
  ) u_pick (
    .req  (req_valid),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q;
  logic             to_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if (state_q == LAUNCH) cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;
      // Remembers why WAIT was left so COMPLETE can flag an abort.
      if (state_q == WAIT) to_q <= to_hit;
    end
  end

  always_comb begin
    to_hit      = (state_q == WAIT) && !tx_done && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    timeout_err = (state_q == COMPLETE) && to_q;
  end
`else
  always_comb begin
    to_hit      = 1'b0;
    timeout_err = 1'b0;
  end
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    req_done  = '0;
    tx_start  = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // rst gating keeps ready low while the reset edge is pending.
        if (enable && pick_any && !rst) begin
          req_ready = pick_gnt;
          accept    = 1'b1;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (tx_done || to_hit) state_d = COMPLETE;
      end
      COMPLETE: begin
        req_done[owner_q] = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      owner_q   <= '0;
      last_q    <= OWNER_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      if (accept) begin
        tx_data_q <= req_data[pick_idx*DATA_W +: DATA_W];
        owner_q   <= pick_idx;
      end
      if (state_q == COMPLETE) last_q <= owner_q;
    end
  end

  assign tx_data = tx_data_q;
  assign owner   = owner_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  req_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [1:0]  owner;
  logic        timeout_err;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .DATA_W      (8),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .req_done    (req_done),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .owner       (owner),
    .timeout_err (timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; req_valid = 4'hF; req_data = 32'h13121110; tx_done = 1'b0;
    step(); step(); step();
    total++;
    if ({tx_start, tx_data, req_ready, req_done, busy, owner, timeout_err} !== 20'h0) begin
      $display("FAIL reset_outputs: got start=%b data=%h ready=%b done=%b busy=%b owner=%0d err=%b, expected all 0",
               tx_start, tx_data, req_ready, req_done, busy, owner, timeout_err);
    end else pass_cnt++;
    req_valid = 4'h0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic bad;
    req_data  = 32'h00A50000;
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b expected 0100", req_ready);
    else pass_cnt++;
    step();
    req_valid = 4'b0000;
    total++;
    if ({tx_start, tx_data, owner, busy} !== {1'b1, 8'hA5, 2'd2, 1'b1})
      $display("FAIL single_launch: got start=%b data=%h owner=%0d busy=%b expected 1 a5 2 1",
               tx_start, tx_data, owner, busy);
    else pass_cnt++;
    bad = 1'b0;
    for (int k = 2; k <= 13; k++) begin
      step();
      if (tx_start !== 1'b0 || req_done !== 4'b0 || busy !== 1'b1 || tx_data !== 8'hA5) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL single_wait: got unexpected activity, expected quiet hold of a5");
    else pass_cnt++;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    total++;
    if (req_done !== 4'b0100 || busy !== 1'b1)
      $display("FAIL single_done: got done=%b busy=%b expected 0100 1", req_done, busy);
    else pass_cnt++;
    step();
    total++;
    if (busy !== 1'b0 || req_done !== 4'b0 || owner !== 2'd2)
      $display("FAIL single_idle: got busy=%b done=%b owner=%0d expected 0 0000 2", busy, req_done, owner);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic bad;
    rst = 1'b1; step(); rst = 1'b0;
    req_data  = 32'h13121110;
    req_valid = 4'hF;
    #1;
    bad = 1'b0;
    for (int n = 0; n < 5; n++) begin
      total++;
      if (req_ready !== (4'b1 << exp_order[n]))
        $display("FAIL rr_ready_%0d: got %b expected %b", n, req_ready, 4'b1 << exp_order[n]);
      else pass_cnt++;
      step();
      if (req_ready !== 4'b0) bad = 1'b1;
      total++;
      if (tx_start !== 1'b1 || tx_data !== (8'h10 + 8'(exp_order[n])) || owner !== 2'(exp_order[n]))
        $display("FAIL rr_launch_%0d: got start=%b data=%h owner=%0d expected 1 %h %0d",
                 n, tx_start, tx_data, owner, 8'h10 + 8'(exp_order[n]), exp_order[n]);
      else pass_cnt++;
      step();
      if (req_ready !== 4'b0) bad = 1'b1;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      if (req_ready !== 4'b0) bad = 1'b1;
      total++;
      if (req_done !== (4'b1 << exp_order[n]))
        $display("FAIL rr_done_%0d: got %b expected %b", n, req_done, 4'b1 << exp_order[n]);
      else pass_cnt++;
      step();
    end
    total++;
    if (bad) $display("FAIL rr_holdoff: got ready outside IDLE, expected 0000");
    else pass_cnt++;
    req_valid = 4'h0;
  endtask

  task automatic test_enable();
    logic bad;
    enable    = 1'b0;
    req_valid = 4'b1010;
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (req_ready !== 4'b0 || tx_start !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL en_block: got grant activity while disabled, expected none");
    else pass_cnt++;
    enable = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0010) $display("FAIL en_grant: got %b expected 0010", req_ready);
    else pass_cnt++;
    step();
    enable = 1'b0;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    total++;
    if (req_done !== 4'b0010) $display("FAIL en_complete: got %b expected 0010", req_done);
    else pass_cnt++;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (req_ready !== 4'b0 || tx_start !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL en_no_regrant: got activity after disable, expected none");
    else pass_cnt++;
    req_valid = 4'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1000;
    step();
    req_valid = 4'b0;
    step();
    req_valid = 4'b1000;
    rst = 1'b1;
    step();
    total++;
    if ({tx_start, tx_data, req_ready, req_done, busy, owner, timeout_err} !== 20'h0)
      $display("FAIL midreset_outputs: got start=%b data=%h ready=%b done=%b busy=%b owner=%0d err=%b, expected all 0",
               tx_start, tx_data, req_ready, req_done, busy, owner, timeout_err);
    else pass_cnt++;
    rst = 1'b0;
    req_valid = 4'hF;
    req_data  = 32'h44332211;
    #1;
    total++;
    if (req_ready !== 4'b0001) $display("FAIL midreset_first: got %b expected 0001", req_ready);
    else pass_cnt++;
    step();
    req_valid = 4'b0;
    total++;
    if (tx_data !== 8'h11 || owner !== 2'd0)
      $display("FAIL midreset_launch: got data=%h owner=%0d expected 11 0", tx_data, owner);
    else pass_cnt++;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    total++;
    if (req_done !== 4'b0001) $display("FAIL midreset_done: got %b expected 0001", req_done);
    else pass_cnt++;
    step();
  endtask

  task automatic test_spurious();
    logic bad;
    tx_done = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (busy !== 1'b0 || req_done !== 4'b0) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL spur_idle: got busy/done on idle tx_done, expected none");
    else pass_cnt++;
    req_valid = 4'b0010;
    req_data  = 32'h00005A00;
    step();
    req_valid = 4'b0;
    step();
    tx_done = 1'b0;
    total++;
    if (busy !== 1'b1 || req_done !== 4'b0 || tx_start !== 1'b0)
      $display("FAIL spur_launch: got busy=%b done=%b start=%b expected 1 0000 0", busy, req_done, tx_start);
    else pass_cnt++;
    step();
    total++;
    if (busy !== 1'b1 || req_done !== 4'b0)
      $display("FAIL spur_wait: got busy=%b done=%b expected 1 0000", busy, req_done);
    else pass_cnt++;
    tx_done = 1'b1;
    step();
    total++;
    if (req_done !== 4'b0010 || tx_data !== 8'h5A)
      $display("FAIL spur_done: got done=%b data=%h expected 0010 5a", req_done, tx_data);
    else pass_cnt++;
    step();
    tx_done = 1'b0;
    step();
    total++;
    if (busy !== 1'b0 || req_done !== 4'b0)
      $display("FAIL spur_complete: got busy=%b done=%b expected 0 0000", busy, req_done);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic bad;
    req_data  = 32'hD4C30000;
    req_valid = 4'b1100;
    step();
    req_valid = 4'b1000;
    step();
    bad = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      if (busy !== 1'b1 || req_done !== 4'b0 || timeout_err !== 1'b0) bad = 1'b1;
      step();
    end
    total++;
    if (bad) $display("FAIL to_wait: got early completion, expected 16 quiet WAIT cycles");
    else pass_cnt++;
    total++;
    if (req_done !== 4'b0100 || timeout_err !== 1'b1)
      $display("FAIL to_abort: got done=%b err=%b expected 0100 1", req_done, timeout_err);
    else pass_cnt++;
    step();
    total++;
    if (req_ready !== 4'b1000 || timeout_err !== 1'b0)
      $display("FAIL to_next: got ready=%b err=%b expected 1000 0", req_ready, timeout_err);
    else pass_cnt++;
`else
    for (int k = 0; k < 40; k++) begin
      if (busy !== 1'b1 || req_done !== 4'b0 || timeout_err !== 1'b0) bad = 1'b1;
      step();
    end
    total++;
    if (bad) $display("FAIL to_unbounded: got WAIT exit without tx_done, expected none");
    else pass_cnt++;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    total++;
    if (req_done !== 4'b0100 || timeout_err !== 1'b0)
      $display("FAIL to_late_done: got done=%b err=%b expected 0100 0", req_done, timeout_err);
    else pass_cnt++;
    step();
    total++;
    if (req_ready !== 4'b1000) $display("FAIL to_next: got ready=%b expected 1000", req_ready);
    else pass_cnt++;
`endif
    step();
    req_valid = 4'b0;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    total++;
    if (req_done !== 4'b1000 || tx_data !== 8'hD4)
      $display("FAIL to_second: got done=%b data=%h expected 1000 d4", req_done, tx_data);
    else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_enable();
    test_reset_mid();
    test_spurious();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
- Accepts one byte at a time from a requester over a valid/ready handshake.
- Launches the byte with a single-cycle tx_start pulse and holds tx_data stable until the transmitter's tx_done pulse.
- Returns a per-requester completion pulse.
- Sits between the client logic (command/status/log sources) and the UART transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 8, byte width; must match the transmitter data width.
- TIMEOUT_CYC, 4096, watchdog limit in clk cycles (used only with UART_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  when low, no new grants; an in-flight byte still completes.
- req_valid  in  NUM_REQ  requester i has a byte pending.
- req_data  in  NUM_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept pulse; transfer occurs when valid & ready.
- req_done  out  NUM_REQ  one-cycle pulse to the owner when its byte finishes.
- tx_start  out  1  one-cycle launch pulse to the transmitter.
- tx_data  out  DATA_W  byte to transmit, stable from LAUNCH through COMPLETE.
- tx_done  in  1  transmitter completion pulse.
- busy  out  1  high in any state other than IDLE.
- owner  out  max(1,$clog2(NUM_REQ))  index of the current or last granted requester.
- timeout_err  out  1  one-cycle pulse on watchdog abort; tied 0 without the macro.

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - State goes to IDLE.
  - All outputs are 0: tx_start, tx_data, req_ready, req_done, busy, owner, timeout_err.
  - RR pointer last_q is set to NUM_REQ-1, so requester 0 wins first.
  - Reset mid-operation abandons the byte with no req_done. The next grant starts fresh.
- FSM states IDLE, LAUNCH, WAIT, COMPLETE:
  - IDLE: if enable and |req_valid, pick winner g, the first valid index searching from last_q+1 modulo NUM_REQ.
    - req_ready[g]=1 combinationally in this cycle; all other ready bits are 0.
    - Latch req_data[g] into tx_data and g into owner.
    - Go to LAUNCH.
    - Otherwise stay in IDLE.
  - LAUNCH: tx_start=1 for exactly this cycle, decoded from state. tx_done is ignored here. Go to WAIT.
  - WAIT: hold tx_data. On tx_done=1, go to COMPLETE.
  - COMPLETE: req_done[owner]=1 for one cycle, last_q<=owner, then go to IDLE.
- Latency: accept at cycle 0, tx_start at cycle 1, req_done one cycle after the tx_done cycle.
- Minimum turnaround between consecutive grants: 4 cycles (accept, LAUNCH, WAIT with tx_done, COMPLETE).
- req_ready is only ever high in IDLE. Valid seen in other states is held off with no loss.
- A requester may drop valid before ready with no effect. Data must be held until the ready cycle.
- Fairness: a requester holding valid continuously is granted within NUM_REQ grants.
- enable deasserted during LAUNCH/WAIT: the in-flight byte completes normally; no regrant afterwards.
- tx_done coinciding with new valids: COMPLETE runs first, then IDLE arbitrates with the updated pointer.
- Spurious tx_done in IDLE, LAUNCH or COMPLETE: ignored, no state change.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC-1 without tx_done, go to COMPLETE.
  - COMPLETE then pulses timeout_err together with req_done[owner].
- Undefined: no counter is built, timeout_err is constant 0, and WAIT waits indefinitely.

Decomposition:
- Package uart_arb_pkg: state_t enum (IDLE, LAUNCH, WAIT, COMPLETE) and the default constants for NUM_REQ and DATA_W.
- Sub-module uart_rr_pick: combinational rotating-priority picker.
  - Inputs: req vector, last index.
  - Outputs: one-hot grant, grant index, any flag.

Test Plan:
- Single requester 2 valid with 0xA5, bench transmitter returning tx_done 12 cycles after tx_start -> req_ready[2] at cycle 0, tx_start at cycle 1 with tx_data=0xA5, req_done[2] one cycle after tx_done, busy falls.
- All 4 valid continuously with bytes 0x10..0x13 -> grant order 0,1,2,3,0 and tx_data sequence matches; never two ready bits high at once.
- enable=0 with valids pending -> no ready and no tx_start. Raise enable -> grant within 1 cycle. Drop enable in WAIT -> byte still completes, no further grant.
- Assert rst during WAIT -> next cycle IDLE with all outputs 0, no req_done. After release, requester 0 is granted first.
- Spurious tx_done pulses in IDLE and LAUNCH -> no req_done, FSM unaffected.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, tx_done never returned -> timeout_err and req_done[owner] pulse together 16 cycles after entering WAIT, then the next requester is served.
